// File: rtl/onehot_dec_pkg.sv
// -----------------------------------------------------------------------------
// onehot_dec_pkg
//   Shared types and constants for the one-hot grant decoder slice.
//   - state_t  : controller states (IDLE / GRANT / GAP)
//   - DEF_N    : default number of grant lines
//   - DEF_HOLD : default maximum grant length without acknowledge
//   - safe_w() : $clog2 that never returns 0, for use as a vector width
// -----------------------------------------------------------------------------
package onehot_dec_pkg;

  localparam int unsigned DEF_N    = 8;
  localparam int unsigned DEF_HOLD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Width needed to index/count v distinct values; at least one bit so that
  // degenerate parameter values still produce legal vectors.
  function automatic int unsigned safe_w(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/onehot_grant_decoder_if.sv
// -----------------------------------------------------------------------------
// onehot_grant_decoder_if
//   Bundles the request handshake and grant-side signals of the one-hot grant
//   decoder.
//   Parameters: N - number of grant lines (index width derived from it)
//   Signals:
//     in_valid    request present            (master -> slave)
//     in_ready    decoder can accept         (slave  -> master)
//     in_idx      encoded index              (master -> slave)
//     in_f        encoder any-active flag    (master -> slave)
//     out_onehot  registered one-hot grant   (slave  -> master)
//     out_ack     target releases grant      (master -> slave)
//     out_empty   empty-request pulse        (slave  -> master)
//     out_timeout hold-expiry pulse          (slave  -> master)
//     err         sticky out-of-range flag   (slave  -> master)
//   Modports: master (arbiter/target side), slave (decoder side).
// -----------------------------------------------------------------------------
interface onehot_grant_decoder_if #(
  parameter int unsigned N = onehot_dec_pkg::DEF_N
);

  localparam int unsigned IW = onehot_dec_pkg::safe_w(N);

  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_idx;
  logic          in_f;
  logic [N-1:0]  out_onehot;
  logic          out_ack;
  logic          out_empty;
  logic          out_timeout;
  logic          err;

  modport master (
    output in_valid,
    output in_idx,
    output in_f,
    output out_ack,
    input  in_ready,
    input  out_onehot,
    input  out_empty,
    input  out_timeout,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_idx,
    input  in_f,
    input  out_ack,
    output in_ready,
    output out_onehot,
    output out_empty,
    output out_timeout,
    output err
  );

endinterface

// File: rtl/onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
//   Purely combinational index-to-one-hot decoder.
//   Ports:
//     i_idx    [IW-1:0] encoded index
//     i_en              enable; 0 forces an all-zero result
//     o_onehot [N-1:0]  one-hot result; all zero when disabled or i_idx >= N
//   Parameters: N (grant lines), IW (index width).
// -----------------------------------------------------------------------------
module onehot_dec #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [IW-1:0] i_idx,
  input  logic          i_en,
  output logic [N-1:0]  o_onehot
);

  // Only indices 0..N-1 have a matching line, so an out-of-range index
  // naturally decodes to zero; callers use that to detect range errors.
  always_comb begin
    o_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_en && (i_idx == IW'(i))) begin
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_grant_decoder.sv
// -----------------------------------------------------------------------------
// onehot_grant_decoder
//   Accepts an encoded index + any-active flag over a valid/ready handshake and
//   drives the matching registered one-hot grant line. The grant is held until
//   out_ack is sampled or HOLD cycles elapse, then a single all-zero GAP cycle
//   separates it from the next grant.
//
//   Ports:
//     clk    clock, all logic on the rising edge
//     rst_n  synchronous active-low reset
//     bus    onehot_grant_decoder_if.slave (handshake, grant, status pulses)
//   Parameters:
//     N    number of grant lines (>= 2)
//     HOLD maximum grant cycles without ack (>= 1)
//
//   Build option ONEHOT_RANGE_CHECK_EN:
//     defined   - in_f=1 with in_idx >= N is dropped and sets sticky err
//     undefined - such a request is treated like in_f=0; err is tied low
// -----------------------------------------------------------------------------
module onehot_grant_decoder
  import onehot_dec_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned HOLD = DEF_HOLD
) (
  input logic                   clk,
  input logic                   rst_n,
  onehot_grant_decoder_if.slave bus
);

  localparam int unsigned   IW        = safe_w(N);
  localparam int unsigned   CW        = safe_w(HOLD + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [N-1:0]  r_onehot;
  logic [N-1:0]  w_onehot_nxt;
  logic [N-1:0]  w_dec;
  logic          r_empty;
  logic          w_empty_nxt;
  logic          r_timeout;
  logic          w_timeout_nxt;

  logic          w_accept;
  logic          w_req_hit;
  logic          w_drop;
  logic          w_grant_end;

  // ---------------------------------------------------------------------------
  // Index decode: a non-zero result means "valid in-range request".
  // ---------------------------------------------------------------------------
  onehot_dec #(
    .N  (N),
    .IW (IW)
  ) u_dec (
    .i_idx    (bus.in_idx),
    .i_en     (bus.in_f),
    .o_onehot (w_dec)
  );

  assign w_accept    = bus.in_valid && (r_state == IDLE);
  assign w_req_hit   = |w_dec;
  assign w_grant_end = bus.out_ack || (r_cnt == '0);

`ifdef ONEHOT_RANGE_CHECK_EN
  // in_f=1 that decodes to nothing is an out-of-range index: drop it silently.
  assign w_drop = bus.in_f && !w_req_hit;
`else
  assign w_drop = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register (also holds the registered outputs).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_onehot  <= '0;
      r_empty   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_onehot  <= w_onehot_nxt;
      r_empty   <= w_empty_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The hold counter is loaded with HOLD-1 on acceptance so
  // that a count of zero marks the last permitted grant cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept && w_req_hit) begin
          w_state_nxt = GRANT;
          w_cnt_nxt   = HOLD_LOAD;
        end
      end
      GRANT: begin
        if (w_grant_end) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs.
  // Ack has priority over expiry, so an ack in the last hold cycle yields no
  // timeout pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_onehot_nxt  = r_onehot;
    w_empty_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_onehot_nxt = '0;
        if (w_accept) begin
          if (w_req_hit) begin
            w_onehot_nxt = w_dec;
          end else if (!w_drop) begin
            w_empty_nxt  = 1'b1;
          end
        end
      end
      GRANT: begin
        if (w_grant_end) begin
          w_onehot_nxt  = '0;
          w_timeout_nxt = !bus.out_ack;
        end
      end
      GAP: begin
        w_onehot_nxt = '0;
      end
      default: begin
        w_onehot_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sticky range error.
  // ---------------------------------------------------------------------------
`ifdef ONEHOT_RANGE_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && w_drop) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_onehot  = r_onehot;
  assign bus.out_empty   = r_empty;
  assign bus.out_timeout = r_timeout;

  // The grant bus must never carry more than one active line.
  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_onehot));

endmodule

// File: tb/tb_onehot_grant_decoder.sv
module tb_onehot_grant_decoder;

  localparam int NC = 400;
  localparam int H8 = 4;
  localparam int H6 = 2;

  localparam bit RC =
`ifdef ONEHOT_RANGE_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       t_valid;
  logic       t_f;
  logic       t_ack;
  logic [2:0] t_idx;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  onehot_grant_decoder_if #(.N(8)) bus8();
  onehot_grant_decoder_if #(.N(6)) bus6();

  assign bus8.in_valid = t_valid;
  assign bus8.in_idx   = t_idx;
  assign bus8.in_f     = t_f;
  assign bus8.out_ack  = t_ack;
  assign bus6.in_valid = t_valid;
  assign bus6.in_idx   = t_idx;
  assign bus6.in_f     = t_f;
  assign bus6.out_ack  = t_ack;

  onehot_grant_decoder #(.N(8), .HOLD(H8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  onehot_grant_decoder #(.N(6), .HOLD(H6)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  typedef struct {
    logic [2:0] idx;
    logic       f;
    int         ack_at;   // grant cycle in which ack is raised, 0 = never
    logic [7:0] oh;       // expected grant pattern
    int         len;      // expected grant length in cycles
    logic       to;       // timeout pulse expected
    logic       empty;    // empty pulse expected
  } vec_t;

  vec_t tbl[6];

  // random stimulus and reference timelines
  logic       s_valid[NC];
  logic       s_f[NC];
  logic       s_ack[NC];
  logic [2:0] s_idx[NC];
  logic [7:0] e_oh[2][NC];
  bit         e_rdy[2][NC];
  bit         e_emp[2][NC];
  bit         e_to[2][NC];
  bit         e_err[2][NC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    t_valid = 1'b0;
    t_f     = 1'b0;
    t_ack   = 1'b0;
    t_idx   = 3'd0;
    step();
    rst_n   = 1'b1;
  endtask

  // Transaction-level reference: each accepted request claims a window of
  // cycles [t+1 .. end] for its grant, then one gap cycle; ready returns at
  // end+2. The window end is the first ack inside the hold window, else
  // t+hold with a timeout pulse right after.
  task automatic build_model(input int d, input int n, input int hold);
    int free_at;
    int err_from;
    free_at  = 0;
    err_from = NC + 1;
    for (int t = 0; t < NC; t++) begin
      e_oh[d][t]  = 8'h00;
      e_rdy[d][t] = 1'b1;
      e_emp[d][t] = 1'b0;
      e_to[d][t]  = 1'b0;
      e_err[d][t] = 1'b0;
    end
    for (int t = 0; t < NC; t++) begin
      if (t < free_at) begin
        e_rdy[d][t] = 1'b0;
        continue;
      end
      if (!s_valid[t]) continue;
      if (s_f[t] && (int'(s_idx[t]) < n)) begin
        int  last;
        bit  tmo;
        last = t + hold;
        tmo  = 1'b1;
        for (int j = t + 1; j <= t + hold; j++) begin
          if (s_ack[j]) begin
            last = j;
            tmo  = 1'b0;
            break;
          end
        end
        for (int c = t + 1; c <= last; c++) e_oh[d][c] = 8'd1 << s_idx[t];
        if (tmo) e_to[d][last + 1] = 1'b1;
        free_at = last + 2;
      end else if (RC && s_f[t]) begin
        if (err_from > t + 1) err_from = t + 1;
      end else begin
        e_emp[d][t + 1] = 1'b1;
      end
    end
    for (int t = 0; t < NC; t++) if (t >= err_from) e_err[d][t] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{3'd3, 1'b1, 2, 8'b00001000, 2, 1'b0, 1'b0};
    tbl[1] = '{3'd7, 1'b1, 0, 8'b10000000, 4, 1'b1, 1'b0};
    tbl[2] = '{3'd5, 1'b0, 0, 8'b00000000, 0, 1'b0, 1'b1};
    tbl[3] = '{3'd0, 1'b1, 1, 8'b00000001, 1, 1'b0, 1'b0};
    tbl[4] = '{3'd6, 1'b1, 4, 8'b01000000, 4, 1'b0, 1'b0};
    tbl[5] = '{3'd1, 1'b1, 0, 8'b00000010, 4, 1'b1, 1'b0};

    // ---------------- reset values
    do_reset();
    sample();
    check("rst8 ready",   bus8.in_ready,    1);
    check("rst8 onehot",  bus8.out_onehot,  0);
    check("rst8 empty",   bus8.out_empty,   0);
    check("rst8 timeout", bus8.out_timeout, 0);
    check("rst8 err",     bus8.err,         0);
    check("rst6 ready",   bus6.in_ready,    1);
    check("rst6 onehot",  bus6.out_onehot,  0);
    check("rst6 err",     bus6.err,         0);
    step();

    // ---------------- table-driven single transactions on the N=8 instance
    for (int k = 0; k < 6; k++) begin
      t_valid = 1'b1;
      t_idx   = tbl[k].idx;
      t_f     = tbl[k].f;
      t_ack   = 1'b0;
      sample();
      check($sformatf("tbl%0d ready@0", k), bus8.in_ready, 1);
      step();
      t_valid = 1'b0;
      for (int c = 1; c <= H8 + 2; c++) begin
        t_ack = (tbl[k].ack_at == c);
        sample();
        check($sformatf("tbl%0d onehot@%0d", k, c), bus8.out_onehot,
              (c <= tbl[k].len) ? tbl[k].oh : 8'h00);
        check($sformatf("tbl%0d timeout@%0d", k, c), bus8.out_timeout,
              32'(tbl[k].to && (c == tbl[k].len + 1)));
        check($sformatf("tbl%0d empty@%0d", k, c), bus8.out_empty,
              32'(tbl[k].empty && (c == 1)));
        check($sformatf("tbl%0d ready@%0d", k, c), bus8.in_ready,
              32'((tbl[k].len == 0) || (c >= tbl[k].len + 2)));
        step();
      end
      t_ack = 1'b0;
    end

    // ---------------- valid held high: idx 0 then idx 6, no ack
    t_valid = 1'b1;
    t_f     = 1'b1;
    t_idx   = 3'd0;
    for (int c = 0; c <= 12; c++) begin
      logic [7:0] exp_oh;
      if (c == 1) t_idx = 3'd6;
      sample();
      exp_oh = ((c >= 1) && (c <= 4))  ? 8'h01 :
               ((c >= 7) && (c <= 10)) ? 8'h40 : 8'h00;
      check($sformatf("b2b onehot@%0d", c), bus8.out_onehot, exp_oh);
      check($sformatf("b2b onebit@%0d", c), 32'($countones(bus8.out_onehot) <= 1), 1);
      check($sformatf("b2b ready@%0d", c), bus8.in_ready, 32'((c == 0) || (c == 6) || (c == 12)));
      check($sformatf("b2b timeout@%0d", c), bus8.out_timeout, 32'((c == 5) || (c == 11)));
      step();
    end
    t_valid = 1'b0;

    // ---------------- reset asserted in the 2nd grant cycle
    do_reset();
    t_valid = 1'b1;
    t_f     = 1'b1;
    t_idx   = 3'd2;
    sample();
    step();
    t_valid = 1'b0;
    sample();
    check("rstmid onehot@1", bus8.out_onehot, 8'h04);
    step();
    rst_n = 1'b0;
    sample();
    check("rstmid onehot@2", bus8.out_onehot, 8'h04);
    step();
    rst_n = 1'b1;
    for (int c = 3; c <= 8; c++) begin
      sample();
      check($sformatf("rstmid onehot@%0d", c),  bus8.out_onehot,  0);
      check($sformatf("rstmid timeout@%0d", c), bus8.out_timeout, 0);
      check($sformatf("rstmid ready@%0d", c),   bus8.in_ready,    1);
      step();
    end

    // ---------------- out-of-range index on the N=6 instance
    do_reset();
    t_valid = 1'b1;
    t_f     = 1'b1;
    t_idx   = 3'd7;
    sample();
    check("range ready@0", bus6.in_ready, 1);
    step();
    t_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      sample();
      check($sformatf("range onehot@%0d", c), bus6.out_onehot, 0);
      check($sformatf("range err@%0d", c),    bus6.err,        32'(RC));
      check($sformatf("range empty@%0d", c),  bus6.out_empty,  32'(!RC && (c == 1)));
      check($sformatf("range ready@%0d", c),  bus6.in_ready,   1);
      check($sformatf("range err8@%0d", c),   bus8.err,        0);
      step();
    end
    t_valid = 1'b1;
    t_idx   = 3'd5;
    sample();
    step();
    t_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      sample();
      check($sformatf("range grant5@%0d", c), bus6.out_onehot, 32'h20);
      check($sformatf("range sticky@%0d", c), bus6.err,        32'(RC));
      step();
    end
    do_reset();
    sample();
    check("range err cleared", bus6.err, 0);
    step();

    // ---------------- randomized run against the transaction model
    for (int t = 0; t < NC; t++) begin
      s_valid[t] = (t < NC - 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_f[t]     = ($urandom_range(0, 4) != 0);
      s_idx[t]   = 3'($urandom_range(0, 7));
      s_ack[t]   = ($urandom_range(0, 9) < 3);
    end
    build_model(0, 8, H8);
    build_model(1, 6, H6);
    do_reset();
    for (int t = 0; t < NC; t++) begin
      t_valid = s_valid[t];
      t_f     = s_f[t];
      t_idx   = s_idx[t];
      t_ack   = s_ack[t];
      sample();
      check($sformatf("rnd8 onehot t=%0d", t),  bus8.out_onehot,  e_oh[0][t]);
      check($sformatf("rnd8 ready t=%0d", t),   bus8.in_ready,    e_rdy[0][t]);
      check($sformatf("rnd8 empty t=%0d", t),   bus8.out_empty,   e_emp[0][t]);
      check($sformatf("rnd8 timeout t=%0d", t), bus8.out_timeout, e_to[0][t]);
      check($sformatf("rnd8 err t=%0d", t),     bus8.err,         e_err[0][t]);
      check($sformatf("rnd6 onehot t=%0d", t),  bus6.out_onehot,  e_oh[1][t]);
      check($sformatf("rnd6 ready t=%0d", t),   bus6.in_ready,    e_rdy[1][t]);
      check($sformatf("rnd6 empty t=%0d", t),   bus6.out_empty,   e_emp[1][t]);
      check($sformatf("rnd6 timeout t=%0d", t), bus6.out_timeout, e_to[1][t]);
      check($sformatf("rnd6 err t=%0d", t),     bus6.err,         e_err[1][t]);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
